// File: rtl/sequential_load.sv
// Load-side sequential path: strips head/tail nibbles from AXI R beats and packs
// the surviving nibbles into lane-line images for the ShuffleUnit.
module sequential_load #(
  parameter  int unsigned NrLanes          = 4,
  parameter  int unsigned Dlen             = 64,
  parameter  int unsigned AxiDataWidth     = 128,
  parameter  int unsigned MetaDep          = 2,
  localparam int unsigned NrLaneEntriesNbs = Dlen / 4 * NrLanes,
  localparam int unsigned BusNibbles       = AxiDataWidth / 4,
  localparam int unsigned BusNSize         = $clog2(BusNibbles)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          axi_r_valid_i,
  output logic                          axi_r_ready_o,
  input  logic [AxiDataWidth-1:0]       axi_r_data_i,
  input  logic                          axi_r_last_i,
  input  logic                          txn_ctrl_valid_i,
  output logic                          txn_ctrl_ready_o,
  input  logic [BusNSize-1:0]           txn_ctrl_addr_i,
  input  logic                          txn_ctrl_is_head_i,
  input  logic [7:0]                    txn_ctrl_rmn_beat_i,
  input  logic [BusNSize:0]             txn_ctrl_lbn_i,
  input  logic                          txn_ctrl_is_final_txn_i,
  input  logic                          meta_glb_valid_i,
  output logic                          meta_glb_ready_o,
  input  logic [63:0]                   meta_vstart_i,
  input  logic [1:0]                    meta_sew_i,
  output logic                          tx_shfu_valid_o,
  input  logic                          tx_shfu_ready_i,
  output logic [4*NrLaneEntriesNbs-1:0] tx_shfu_nb_o,
  output logic [NrLaneEntriesNbs-1:0]   tx_shfu_en_o
);

  localparam int unsigned PtrW  = $clog2(NrLaneEntriesNbs);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned NbW   = 4 * NrLaneEntriesNbs;
  localparam int unsigned MIdxW = (MetaDep > 1) ? $clog2(MetaDep) : 1;

  typedef enum logic {IDLE, SERIAL} state_e;

  state_e state_q, state_d;

  logic                  unused_sig;
  logic [PtrW-1:0]       meta_ptr;
  logic [PtrW-1:0]       meta_mem_q [MetaDep];
  logic [MIdxW:0]        meta_wr_q, meta_rd_q;
  logic                  meta_full, meta_empty, meta_push, meta_pop;

  logic [PtrW-1:0]       seq_nb_ptr_q;
  logic [BusNSize-1:0]   bus_nb_cnt_q;
  logic [NbW-1:0]        line_nb_q;
  logic [NrLaneEntriesNbs-1:0] line_en_q;

  logic [CntW-1:0]       lower, upper, bus_valid, line_free, start, copy_n;
  logic                  split, final_beat, step, consume, push;
  logic [NbW-1:0]        bus_ext, shifted, merged_nb;
  logic [NrLaneEntriesNbs-1:0] copy_en, merged_en;

  logic [NbW-1:0]        ob_nb_q [2];
  logic [NrLaneEntriesNbs-1:0] ob_en_q [2];
  logic [1:0]            ob_wr_q, ob_rd_q;
  logic                  ob_full, ob_empty, ob_pop;

  // Only the low PtrW bits of vstart survive the modulo after shifting by sew.
  assign unused_sig = ^{meta_vstart_i[63:PtrW], axi_r_last_i};
  assign meta_ptr   = meta_vstart_i[PtrW-1:0] << meta_sew_i;

  assign meta_full  = (meta_wr_q[MIdxW] != meta_rd_q[MIdxW]) &&
                      (meta_wr_q[MIdxW-1:0] == meta_rd_q[MIdxW-1:0]);
  assign meta_empty = (meta_wr_q == meta_rd_q);
  assign meta_push  = meta_glb_valid_i && !meta_full;
  assign meta_glb_ready_o = !meta_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_wr_q <= '0;
      meta_rd_q <= '0;
      for (int unsigned i = 0; i < MetaDep; i++) meta_mem_q[i] <= '0;
    end else begin
      if (meta_push) begin
        meta_mem_q[meta_wr_q[MIdxW-1:0]] <= meta_ptr;
        meta_wr_q <= meta_wr_q + 1'b1;
      end
      if (meta_pop) meta_rd_q <= meta_rd_q + 1'b1;
    end
  end

  assign lower      = txn_ctrl_is_head_i ? CntW'(txn_ctrl_addr_i) : '0;
  assign upper      = (txn_ctrl_rmn_beat_i == '0) ? CntW'(txn_ctrl_lbn_i) : CntW'(BusNibbles);
  assign bus_valid  = upper - lower - CntW'(bus_nb_cnt_q);
  assign line_free  = CntW'(NrLaneEntriesNbs) - CntW'(seq_nb_ptr_q);
  assign start      = lower + CntW'(bus_nb_cnt_q);
  assign split      = (bus_valid > line_free);
  assign copy_n     = split ? line_free : bus_valid;
  assign final_beat = txn_ctrl_is_final_txn_i && (txn_ctrl_rmn_beat_i == '0);

  assign ob_full  = (ob_wr_q[0] == ob_rd_q[0]) && (ob_wr_q[1] != ob_rd_q[1]);
  assign ob_empty = (ob_wr_q == ob_rd_q);
  assign ob_pop   = !ob_empty && tx_shfu_ready_i;

  assign step    = (state_q == SERIAL) && axi_r_valid_i && txn_ctrl_valid_i && !ob_full;
  assign consume = step && !split;
  assign push    = step && (split || (bus_valid == line_free) || final_beat);

  // Align bus nibble `start` to line position seq_nb_ptr, then mask by copy window.
  assign bus_ext = NbW'(axi_r_data_i);
  assign shifted = (bus_ext >> {start, 2'b00}) << {seq_nb_ptr_q, 2'b00};

  always_comb begin
    copy_en   = '0;
    merged_nb = line_nb_q;
    for (int unsigned i = 0; i < NrLaneEntriesNbs; i++) begin
      if ((CntW'(i) >= CntW'(seq_nb_ptr_q)) && (CntW'(i) < CntW'(seq_nb_ptr_q) + copy_n)) begin
        copy_en[i]          = 1'b1;
        merged_nb[4*i +: 4] = shifted[4*i +: 4];
      end
    end
  end
  assign merged_en = line_en_q | copy_en;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (txn_ctrl_valid_i && !meta_empty) state_d = SERIAL;
      SERIAL:  if (consume && final_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    meta_pop         = 1'b0;
    axi_r_ready_o    = 1'b0;
    txn_ctrl_ready_o = 1'b0;
    case (state_q)
      IDLE:    meta_pop = txn_ctrl_valid_i && !meta_empty;
      SERIAL: begin
        axi_r_ready_o    = consume;
        txn_ctrl_ready_o = consume;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seq_nb_ptr_q <= '0;
      bus_nb_cnt_q <= '0;
      line_nb_q    <= '0;
      line_en_q    <= '0;
    end else if (meta_pop) begin
      seq_nb_ptr_q <= meta_mem_q[meta_rd_q[MIdxW-1:0]];
      bus_nb_cnt_q <= '0;
    end else if (step) begin
      if (split) begin
        bus_nb_cnt_q <= BusNSize'(CntW'(bus_nb_cnt_q) + line_free);
        seq_nb_ptr_q <= '0;
      end else begin
        bus_nb_cnt_q <= '0;
        seq_nb_ptr_q <= push ? '0 : PtrW'(CntW'(seq_nb_ptr_q) + bus_valid);
      end
      if (push) begin
        line_nb_q <= '0;
        line_en_q <= '0;
      end else begin
        line_nb_q <= merged_nb;
        line_en_q <= merged_en;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ob_wr_q <= '0;
      ob_rd_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        ob_nb_q[i] <= '0;
        ob_en_q[i] <= '0;
      end
    end else begin
      if (push) begin
        ob_nb_q[ob_wr_q[0]] <= merged_nb;
        ob_en_q[ob_wr_q[0]] <= merged_en;
        ob_wr_q <= ob_wr_q + 2'd1;
      end
      if (ob_pop) ob_rd_q <= ob_rd_q + 2'd1;
    end
  end

  assign tx_shfu_valid_o = !ob_empty;
  assign tx_shfu_nb_o    = ob_nb_q[ob_rd_q[0]];
  assign tx_shfu_en_o    = ob_en_q[ob_rd_q[0]];

  always_ff @(posedge clk_i) begin
    if (rst_ni && (state_q == SERIAL) && axi_r_valid_i && txn_ctrl_valid_i) begin
      assert (bus_valid <= CntW'(BusNibbles));
      assert (line_free <= CntW'(NrLaneEntriesNbs));
    end
    if (rst_ni && axi_r_valid_i && axi_r_ready_o) begin
      assert (axi_r_last_i == (txn_ctrl_rmn_beat_i == '0));
    end
  end

endmodule

// File: tb/tb_sequential_load.sv
// Directed and randomized bench for sequential_load against a nibble-stream
// reference model that packs extracted nibbles into 64-nibble lines.
module tb_sequential_load;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         axi_r_valid_i = 1'b0, axi_r_ready_o;
  logic [127:0] axi_r_data_i = '0;
  logic         axi_r_last_i = 1'b0;
  logic         txn_ctrl_valid_i = 1'b0, txn_ctrl_ready_o;
  logic [4:0]   txn_ctrl_addr_i = '0;
  logic         txn_ctrl_is_head_i = 1'b0;
  logic [7:0]   txn_ctrl_rmn_beat_i = '0;
  logic [5:0]   txn_ctrl_lbn_i = '0;
  logic         txn_ctrl_is_final_txn_i = 1'b0;
  logic         meta_glb_valid_i = 1'b0, meta_glb_ready_o;
  logic [63:0]  meta_vstart_i = '0;
  logic [1:0]   meta_sew_i = '0;
  logic         tx_shfu_valid_o;
  logic         tx_shfu_ready_i = 1'b1;
  logic [255:0] tx_shfu_nb_o;
  logic [63:0]  tx_shfu_en_o;

  sequential_load #(.NrLanes(4), .Dlen(64), .AxiDataWidth(128), .MetaDep(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
    .axi_r_data_i(axi_r_data_i), .axi_r_last_i(axi_r_last_i),
    .txn_ctrl_valid_i(txn_ctrl_valid_i), .txn_ctrl_ready_o(txn_ctrl_ready_o),
    .txn_ctrl_addr_i(txn_ctrl_addr_i), .txn_ctrl_is_head_i(txn_ctrl_is_head_i),
    .txn_ctrl_rmn_beat_i(txn_ctrl_rmn_beat_i), .txn_ctrl_lbn_i(txn_ctrl_lbn_i),
    .txn_ctrl_is_final_txn_i(txn_ctrl_is_final_txn_i),
    .meta_glb_valid_i(meta_glb_valid_i), .meta_glb_ready_o(meta_glb_ready_o),
    .meta_vstart_i(meta_vstart_i), .meta_sew_i(meta_sew_i),
    .tx_shfu_valid_o(tx_shfu_valid_o), .tx_shfu_ready_i(tx_shfu_ready_i),
    .tx_shfu_nb_o(tx_shfu_nb_o), .tx_shfu_en_o(tx_shfu_en_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [255:0] nb; logic [63:0] en; } line_t;

  line_t        exp_q[$];
  line_t        mon_e;
  int           checks = 0, failures = 0, lines_seen = 0;
  bit           rand_bp = 1'b0;
  logic [127:0] b_data [16];
  int           b_addr [16], b_rmn [16], b_lbn [16];
  bit           b_head [16], b_final [16];
  int           nbeats = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every popped line is compared with the oldest model line.
  always @(negedge clk_i) begin
    if (rst_ni && tx_shfu_valid_o && tx_shfu_ready_i) begin
      lines_seen++;
      check("line_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("line_nb", tx_shfu_nb_o, mon_e.nb);
        check("line_en", tx_shfu_en_o, mon_e.en);
      end
    end
  end

  task automatic set_beat(input int i, input bit head, input int addr, input int rmn,
                          input int lbn, input bit fin);
    b_data[i]  = {$urandom, $urandom, $urandom, $urandom};
    b_head[i]  = head;
    b_addr[i]  = addr;
    b_rmn[i]   = rmn;
    b_lbn[i]   = lbn;
    b_final[i] = fin;
  endtask

  // Flatten all valid nibbles into one stream, then lay it out from the start offset.
  task automatic model_request(input logic [63:0] vs, input logic [1:0] sew);
    logic [3:0]      stream[$];
    line_t           cur;
    int              pos, lower, upper;
    longint unsigned p;
    p   = vs * (64'd1 << sew);
    pos = int'(p % 64);
    for (int i = 0; i < nbeats; i++) begin
      lower = b_head[i] ? b_addr[i] : 0;
      upper = (b_rmn[i] == 0) ? b_lbn[i] : 32;
      for (int n = lower; n < upper; n++) stream.push_back(b_data[i][4*n +: 4]);
    end
    cur.nb = '0;
    cur.en = '0;
    foreach (stream[k]) begin
      cur.nb[4*pos +: 4] = stream[k];
      cur.en[pos]        = 1'b1;
      pos++;
      if (pos == 64) begin
        exp_q.push_back(cur);
        cur.nb = '0;
        cur.en = '0;
        pos    = 0;
      end
    end
    if (cur.en != '0) exp_q.push_back(cur);
  endtask

  task automatic idle_inputs();
    axi_r_valid_i = 1'b0;
    txn_ctrl_valid_i = 1'b0;
    axi_r_last_i = 1'b0;
    txn_ctrl_addr_i = '0;
    txn_ctrl_is_head_i = 1'b0;
    txn_ctrl_rmn_beat_i = '0;
    txn_ctrl_lbn_i = '0;
    txn_ctrl_is_final_txn_i = 1'b0;
  endtask

  task automatic push_meta(input logic [63:0] vs, input logic [1:0] sew);
    meta_glb_valid_i = 1'b1;
    meta_vstart_i    = vs;
    meta_sew_i       = sew;
    @(negedge clk_i);
    check("meta_accept", meta_glb_ready_o, 1);
    @(posedge clk_i); #1;
    meta_glb_valid_i = 1'b0;
  endtask

  task automatic drive_beats(input int first, input int last, input int max_cyc,
                             output int consumed, output int rdy_cyc, output int crdy_cyc,
                             output int cyc);
    int i;
    bit fire;
    i = first; consumed = 0; rdy_cyc = 0; crdy_cyc = 0; cyc = 0;
    while (i <= last && cyc < max_cyc) begin
      axi_r_valid_i           = 1'b1;
      axi_r_data_i            = b_data[i];
      axi_r_last_i            = (b_rmn[i] == 0);
      txn_ctrl_valid_i        = 1'b1;
      txn_ctrl_addr_i         = 5'(b_addr[i]);
      txn_ctrl_is_head_i      = b_head[i];
      txn_ctrl_rmn_beat_i     = 8'(b_rmn[i]);
      txn_ctrl_lbn_i          = 6'(b_lbn[i]);
      txn_ctrl_is_final_txn_i = b_final[i];
      if (rand_bp) tx_shfu_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk_i);
      fire = axi_r_ready_o;
      if (axi_r_ready_o) rdy_cyc++;
      if (txn_ctrl_ready_o) crdy_cyc++;
      @(posedge clk_i); #1;
      cyc++;
      if (fire) begin
        i++;
        consumed++;
      end
    end
    if (i > last) idle_inputs();
  endtask

  task automatic drain();
    int cyc;
    tx_shfu_ready_i = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(negedge clk_i);
    check("no_extra_line", tx_shfu_valid_o, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic run_request(input logic [63:0] vs, input logic [1:0] sew,
                             output int rdy, output int crdy, output int cyc);
    int cons;
    push_meta(vs, sew);
    model_request(vs, sew);
    drive_beats(0, nbeats - 1, 400, cons, rdy, crdy, cyc);
    check("beats_consumed", cons, nbeats);
    drain();
  endtask

  task automatic check_reset_outputs();
    check("rst_axi_ready", axi_r_ready_o, 0);
    check("rst_ctrl_ready", txn_ctrl_ready_o, 0);
    check("rst_tx_valid", tx_shfu_valid_o, 0);
    check("rst_meta_ready", meta_glb_ready_o, 1);
    check("rst_nb", tx_shfu_nb_o, 0);
    check("rst_en", tx_shfu_en_o, 0);
  endtask

  task automatic setup_aligned();
    nbeats = 2;
    set_beat(0, 1'b1, 0, 1, 32, 1'b1);
    set_beat(1, 1'b0, 0, 0, 32, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cons, rdy, crdy, cyc, l0, nbursts, len, rmn, addr, lbn;
    bit head;
    logic [63:0] vs;
    logic [1:0]  sew;

    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_reset_outputs();
    @(posedge clk_i); #1;

    // Aligned two-beat stream
    setup_aligned();
    l0 = lines_seen;
    run_request(64'd0, 2'd0, rdy, crdy, cyc);
    check("aligned_r_ready_cycles", rdy, 2);
    check("aligned_ctrl_ready_cycles", crdy, 2);
    check("aligned_cycles", cyc, 3);
    check("aligned_lines", lines_seen - l0, 1);

    // Head offset
    nbeats = 1;
    set_beat(0, 1'b1, 8, 0, 32, 1'b1);
    l0 = lines_seen;
    run_request(64'd0, 2'd0, rdy, crdy, cyc);
    check("head_lines", lines_seen - l0, 1);

    // Straddle at vstart 48
    nbeats = 1;
    set_beat(0, 1'b1, 0, 0, 32, 1'b1);
    l0 = lines_seen;
    run_request(64'd48, 2'd0, rdy, crdy, cyc);
    check("straddle_ready_cycles", rdy, 1);
    check("straddle_cycles", cyc, 3);
    check("straddle_lines", lines_seen - l0, 2);

    // Missing meta: control offered with the meta queue empty
    nbeats = 1;
    set_beat(0, 1'b1, 0, 0, 32, 1'b1);
    drive_beats(0, 0, 5, cons, rdy, crdy, cyc);
    check("nometa_consumed", cons, 0);
    check("nometa_r_ready", rdy, 0);
    check("nometa_ctrl_ready", crdy, 0);
    l0 = lines_seen;
    model_request(64'd0, 2'd0);
    push_meta(64'd0, 2'd0);
    drive_beats(0, 0, 10, cons, rdy, crdy, cyc);
    check("meta_late_consumed", cons, 1);
    check("meta_late_cycles", cyc, 2);
    drain();
    check("meta_late_lines", lines_seen - l0, 1);

    // Backpressure: eight full beats with the ShuffleUnit stalled
    nbeats = 8;
    for (int i = 0; i < 8; i++) set_beat(i, i == 0, 0, 7 - i, 32, 1'b1);
    l0 = lines_seen;
    rand_bp = 1'b0;
    tx_shfu_ready_i = 1'b0;
    push_meta(64'd0, 2'd0);
    model_request(64'd0, 2'd0);
    drive_beats(0, 7, 20, cons, rdy, crdy, cyc);
    check("bp_consumed_before_full", cons, 4);
    @(negedge clk_i);
    check("bp_stall_r_ready", axi_r_ready_o, 0);
    check("bp_stall_ctrl_ready", txn_ctrl_ready_o, 0);
    check("bp_tx_valid", tx_shfu_valid_o, 1);
    @(posedge clk_i); #1;
    tx_shfu_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_same_cycle_r_ready", axi_r_ready_o, 0);
    check("bp_same_cycle_ctrl_ready", txn_ctrl_ready_o, 0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("bp_resume_r_ready", axi_r_ready_o, 1);
    check("bp_resume_ctrl_ready", txn_ctrl_ready_o, 1);
    @(posedge clk_i); #1;
    drive_beats(5, 7, 20, cons, rdy, crdy, cyc);
    check("bp_rest_consumed", cons, 3);
    drain();
    check("bp_lines", lines_seen - l0, 4);

    // Reset after one of two beats, with the meta queue filled
    setup_aligned();
    push_meta(64'd0, 2'd0);
    drive_beats(0, 0, 10, cons, rdy, crdy, cyc);
    check("mid_first_consumed", cons, 1);
    push_meta(64'd16, 2'd1);
    push_meta(64'd3, 2'd2);
    @(negedge clk_i);
    check("meta_full_ready", meta_glb_ready_o, 0);
    @(posedge clk_i); #3;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs();
    idle_inputs();
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    setup_aligned();
    l0 = lines_seen;
    run_request(64'd0, 2'd0, rdy, crdy, cyc);
    check("post_rst_r_ready_cycles", rdy, 2);
    check("post_rst_cycles", cyc, 3);
    check("post_rst_lines", lines_seen - l0, 1);

    // Randomized requests with random ShuffleUnit backpressure
    rand_bp = 1'b1;
    for (int r = 0; r < 20; r++) begin
      nbeats  = 0;
      nbursts = $urandom_range(1, 2);
      for (int b = 0; b < nbursts; b++) begin
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++) begin
          head = (j == 0);
          rmn  = len - 1 - j;
          addr = head ? $urandom_range(0, 31) : 0;
          lbn  = (rmn != 0) ? 32 : (head ? $urandom_range(addr + 1, 32) : $urandom_range(1, 32));
          set_beat(nbeats, head, addr, rmn, lbn, b == nbursts - 1);
          nbeats++;
        end
      end
      vs  = {$urandom, $urandom};
      sew = 2'($urandom_range(0, 3));
      run_request(vs, sew, rdy, crdy, cyc);
    end
    rand_bp = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequential_load.md
Name: sequential_load

Overview:
- Load-side counterpart of the sequential store path in the VLSU.
- Consumes AXI R beats and strips the head and tail bytes that lie outside the access, as described by per-beat transaction control.
- Packs the valid nibbles contiguously into lane-line images of NrLaneEntriesNbs nibbles, starting at the vstart offset.
- Hands each full or final line, with per-nibble enables, to the ShuffleUnit.

Parameters:
- NrLanes, 4: number of vector lanes.
- Dlen, 64: per-lane datapath width in bits.
- AxiDataWidth, 128: R data width in bits.
- NrLaneEntriesNbs, Dlen/4*NrLanes (local, = 64): nibbles per line.
- BusNibbles, AxiDataWidth/4 (local, = 32): nibbles per bus beat.
- BusNSize, clog2(BusNibbles) (local, = 5).
- MetaDep, 2: depth of the seq-info queue.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- axi_r_valid_i, in, 1: R beat valid.
- axi_r_ready_o, out, 1: R beat consumed.
- axi_r_data_i, in, AxiDataWidth: R data.
- axi_r_last_i, in, 1: R last.
- txn_ctrl_valid_i, in, 1: per-beat control valid.
- txn_ctrl_ready_o, out, 1: control beat consumed.
- txn_ctrl_addr_i, in, BusNSize: nibble offset of the head beat.
- txn_ctrl_is_head_i, in, 1: first beat of the burst.
- txn_ctrl_rmn_beat_i, in, 8: remaining beats; 0 means last beat.
- txn_ctrl_lbn_i, in, BusNSize+1: exclusive upper nibble bound of the last beat, range 1..BusNibbles.
- txn_ctrl_is_final_txn_i, in, 1: burst is the final one of the request.
- meta_glb_valid_i, in, 1: request meta valid.
- meta_glb_ready_o, out, 1: meta accepted.
- meta_vstart_i, in, 64: vstart.
- meta_sew_i, in, 2: element width code.
- tx_shfu_valid_o, out, 1: line valid.
- tx_shfu_ready_i, in, 1: ShuffleUnit accepts line.
- tx_shfu_nb_o, out, 4*NrLaneEntriesNbs: line nibbles.
- tx_shfu_en_o, out, NrLaneEntriesNbs: nibble enables.

Behaviour:

Reset values:
- axi_r_ready_o, txn_ctrl_ready_o and tx_shfu_valid_o are 0.
- meta_glb_ready_o is 1.
- FSM is IDLE; all queues are empty; the assembly line is cleared (nb and en all 0).

Meta queue:
- MetaDep-entry FIFO storing seq_nb_ptr = (vstart << sew) mod NrLaneEntriesNbs.
- meta_glb_ready_o = queue not full.

FSM IDLE:
- Entry requires txn_ctrl_valid_i and a non-empty meta queue.
- On entry: pop meta, load seq_nb_ptr, clear bus_nb_cnt, and go to SERIAL.
- No R or ctrl handshake occurs in IDLE.

Per-cycle arithmetic in SERIAL (all from the current ctrl beat):
- lower = is_head ? addr : 0.
- upper = (rmn_beat == 0) ? lbn : BusNibbles.
- bus_valid = upper - lower - bus_nb_cnt.
- line_free = NrLaneEntriesNbs - seq_nb_ptr.
- start = lower + bus_nb_cnt.

FSM SERIAL: a step occurs when axi_r_valid_i, txn_ctrl_valid_i, and output buffer not full all hold.
- If bus_valid > line_free:
  - Copy line_free nibbles from bus[start..] into line[seq_nb_ptr..].
  - bus_nb_cnt += line_free; seq_nb_ptr = 0.
  - Push the line. The R beat and ctrl beat are not consumed.
- Otherwise:
  - Copy bus_valid nibbles; bus_nb_cnt = 0; seq_nb_ptr += bus_valid.
  - Assert axi_r_ready_o and txn_ctrl_ready_o together (combinational, same cycle).
  - Push the line and set seq_nb_ptr = 0 if bus_valid == line_free, or if the beat is final (is_final_txn && rmn_beat == 0).
- A final beat consumed in this way returns the FSM to IDLE.

Line enables and clearing:
- Enables are set only for copied nibbles.
- On push the assembly line is cleared in the same cycle.
- Nibbles below the initial seq_nb_ptr on the first line, and above the end on the last line, have en = 0.

Output buffer:
- 2-entry ping-pong with flag/value pointers.
- Full is value-equal with flag-different; empty is value- and flag-equal.
- tx_shfu_valid_o = not empty; nb/en are driven from the dequeue entry.
- Push and pop in the same cycle are allowed.
- Push is allowed only when the buffer is not full, judged on the registered state with no bypass.
- Line latency: a pushed line is visible on tx_shfu_* in the next cycle.

Stalls:
- If the output is full in SERIAL, no step happens and both ready outputs are 0.
- All state is held.

Assertions:
- On an R handshake, axi_r_last_i == (rmn_beat == 0).
- bus_valid <= BusNibbles.
- line_free <= NrLaneEntriesNbs.

Reset mid-operation:
- Asserting rst_ni low asynchronously returns everything to reset values.
- In-flight lines and meta are discarded.

Test Plan:
- Aligned stream: vstart = 0, sew = 0. Two beats with rmn_beat 1,0, lbn = 32, is_final = 1. Required: one line, en = all ones, nb[0..31] = beat0, nb[32..63] = beat1; axi_r_ready_o high on 2 cycles; FSM returns to IDLE.
- Head offset: addr = 8, one final beat, lbn = 32. Required: line nb[0..23] = beat nibbles 8..31, en[23:0] = 1, en[63:24] = 0.
- Straddle: vstart = 48, sew = 0, one full final beat. Required: cycle 1 copies nibbles 0..15 to line positions 48..63, pushes the line, axi_r_ready_o = 0. Cycle 2 copies nibbles 16..31 to positions 0..15 and asserts ready. Two lines are produced, the second with en[15:0] only.
- Backpressure: tx_shfu_ready_i = 0 while streaming 8 full beats. Required: exactly 2 lines are buffered, then axi_r_ready_o and txn_ctrl_ready_o stay 0. They resume the cycle after ready rises.
- Missing meta: txn_ctrl_valid_i = 1 with the meta queue empty. Required: FSM stays IDLE and both ready outputs stay 0. Sending meta starts processing the next cycle.
- Reset mid-transaction after 1 of 2 beats. Required: all outputs take reset values. A following aligned request behaves exactly as in the first scenario.
